// File: rtl/instr_check_pkg.sv
// Shared decode constants, exception codes and the branch-class helper for instr_check_stage.
package instr_check_pkg;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_fields_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22, FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B;

    localparam logic [4:0]  RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;
    localparam logic [4:0]  RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;
    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_RI   = 5'h0A;

    // Branch class: beq bne blez bgtz bltz bgez j jal jr jalr.
    function automatic logic branch_class(input instr_fields_t f);
        case (f.op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL: branch_class = 1'b1;
            OP_REGIMM:  branch_class = (f.rt == RT_BLTZ) || (f.rt == RT_BGEZ);
            OP_SPECIAL: branch_class = (f.funct == FN_JR) || (f.funct == FN_JALR);
            default:    branch_class = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_check_stage_legal_dec.sv
// Combinational legality / branch-class decoder; COP0 words are legal only with INSTR_CHECK_COP0_EN.
module instr_legal_dec
    import instr_check_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        legal_o,
    output logic        is_branch_o
);

    instr_fields_t f;
    assign f = instr_fields_t'(instr_i);

    always_comb begin
        // NOTE: default first so every path assigns legal_o and no latch is inferred.
        legal_o = 1'b0;
        case (f.op)
            OP_SPECIAL: begin
                case (f.funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_JALR,
                    FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: legal_o = 1'b1;
                    default:         legal_o = 1'b0;
                endcase
            end
            OP_REGIMM: legal_o = (f.rt == RT_BLTZ) || (f.rt == RT_BGEZ);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: legal_o = 1'b1;
            OP_COP0: begin
`ifdef INSTR_CHECK_COP0_EN
                legal_o = (f.rs == RS_MFC0) || (f.rs == RS_MTC0) || (instr_i == ERET_WORD);
`else
                legal_o = 1'b0;
`endif
            end
            default: legal_o = 1'b0;
        endcase
    end

    assign is_branch_o = branch_class(f);

endmodule

// File: rtl/instr_check_stage.sv
// One-entry fetch-to-decode check stage: AdEL/RI detection, delay-slot tracking, exception count.
// Optional COP0 legality (mfc0/mtc0/eret) via macro INSTR_CHECK_COP0_EN.
module instr_check_stage
    import instr_check_pkg::*;
#(
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_4FFC,
    parameter int          COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [31:0]        in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic [4:0]         out_exccode,
    output logic               out_bd,
    output logic [COUNT_W-1:0] exc_count
);

    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_instr_q, out_instr_d;
    logic [31:0]        out_pc_q, out_pc_d;
    logic [4:0]         out_exccode_q, out_exccode_d;
    logic               out_bd_q, out_bd_d;
    logic               prev_br_q, prev_br_d;
    logic [COUNT_W-1:0] exc_count_q, exc_count_d;

    logic       legal, is_branch, adel, accept;
    logic [4:0] exccode;

    instr_legal_dec u_dec (
        .instr_i     (in_instr),
        .legal_o     (legal),
        .is_branch_o (is_branch)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign adel     = (in_pc[1:0] != 2'b00) || (in_pc < PC_BASE) || (in_pc > PC_LIMIT);
    assign exccode  = adel ? EXC_ADEL : (!legal ? EXC_RI : EXC_NONE);

    always_comb begin
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        out_exccode_d = out_exccode_q;
        out_bd_d      = out_bd_q;
        prev_br_d     = prev_br_q;
        exc_count_d   = exc_count_q;
        if (flush) begin
            out_valid_d = 1'b0;
            prev_br_d   = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_instr_d   = (exccode == EXC_NONE) ? in_instr : 32'h0;
            out_pc_d      = in_pc;
            out_exccode_d = exccode;
            out_bd_d      = prev_br_q;
            prev_br_d     = is_branch && (exccode == EXC_NONE);
            if (exccode != EXC_NONE && exc_count_q != {COUNT_W{1'b1}})
                exc_count_d = exc_count_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // The payload registers are reset too: outputs must read zero while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= 32'h0;
            out_pc_q      <= 32'h0;
            out_exccode_q <= EXC_NONE;
            out_bd_q      <= 1'b0;
            prev_br_q     <= 1'b0;
            exc_count_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            out_exccode_q <= out_exccode_d;
            out_bd_q      <= out_bd_d;
            prev_br_q     <= prev_br_d;
            exc_count_q   <= exc_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_exccode = out_exccode_q;
    assign out_bd      = out_bd_q;
    assign exc_count   = exc_count_q;

endmodule

// File: tb/tb_instr_check_stage.sv
// Directed self-checking bench for instr_check_stage (COUNT_W=2 to exercise saturation).
module tb_instr_check_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_bd;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [4:0]  out_exccode;
    logic [1:0]  exc_count;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] ADDU  = 32'h0043_0821;
    localparam logic [31:0] BEQ   = 32'h1000_0002;
    localparam logic [31:0] BAD   = 32'hFC00_0000;
    localparam logic [31:0] ADDIU = 32'h2401_0005;
    localparam logic [31:0] ORI   = 32'h3421_0001;
    localparam logic [31:0] ERET  = 32'h4200_0018;
    localparam logic [31:0] MFC0  = 32'h4002_6000;
    localparam logic [31:0] BLTZ  = 32'h0420_0003;
    localparam logic [31:0] BLTZAL = 32'h0430_0001;

`ifdef INSTR_CHECK_COP0_EN
    localparam logic [4:0]  COP0_CODE  = 5'h00;
    localparam logic [31:0] ERET_OUT   = ERET;
    localparam logic [31:0] MFC0_OUT   = MFC0;
`else
    localparam logic [4:0]  COP0_CODE  = 5'h0A;
    localparam logic [31:0] ERET_OUT   = 32'h0;
    localparam logic [31:0] MFC0_OUT   = 32'h0;
`endif

    instr_check_stage #(.COUNT_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_exccode (out_exccode),
        .out_bd      (out_bd),
        .exc_count   (exc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic check_out(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [4:0] code, input logic bd, input logic [1:0] cnt);
        check({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, ".instr"}, out_instr, instr);
        check({tag, ".pc"},    out_pc, pc);
        check({tag, ".code"},  {27'h0, out_exccode}, {27'h0, code});
        check({tag, ".bd"},    {31'h0, out_bd}, {31'h0, bd});
        check({tag, ".cnt"},   {30'h0, exc_count}, {30'h0, cnt});
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        #12;
        check("rst.valid", {31'h0, out_valid}, 32'h0);
        check("rst.ready", {31'h0, in_ready}, 32'h1);
        check("rst.instr", out_instr, 32'h0);
        check("rst.cnt",   {30'h0, exc_count}, 32'h0);
        reset = 1'b1;
        step();

        // Basic accept, latency one
        drive(1'b1, ADDU, 32'h3000); step();
        check_out("addu", ADDU, 32'h3000, 5'h00, 1'b0, 2'd0);
        drive(1'b1, BEQ, 32'h3004); step();
        check_out("beq", BEQ, 32'h3004, 5'h00, 1'b0, 2'd0);
        drive(1'b1, BAD, 32'h3008); step();
        check_out("ri_ds", 32'h0, 32'h3008, 5'h0A, 1'b1, 2'd1);

        // Address errors, boundaries, priority over RI, saturation at 3
        drive(1'b1, ADDU, 32'h3002); step();
        check_out("adel_mis", 32'h0, 32'h3002, 5'h04, 1'b0, 2'd2);
        drive(1'b1, ADDU, 32'h5000); step();
        check_out("adel_hi", 32'h0, 32'h5000, 5'h04, 1'b0, 2'd3);
        drive(1'b1, BAD, 32'h3001); step();
        check_out("adel_pri", 32'h0, 32'h3001, 5'h04, 1'b0, 2'd3);
        drive(1'b1, ADDU, 32'h4FFC); step();
        check_out("pc_limit", ADDU, 32'h4FFC, 5'h00, 1'b0, 2'd3);
        drive(1'b1, ADDU, 32'h2FFC); step();
        check_out("pc_below", 32'h0, 32'h2FFC, 5'h04, 1'b0, 2'd3);

        // Backpressure: held entry frozen for three cycles
        drive(1'b1, ADDIU, 32'h3010); step();
        check_out("stall_a", ADDIU, 32'h3010, 5'h00, 1'b0, 2'd3);
        out_ready = 1'b0;
        drive(1'b1, ORI, 32'h3014); #1;
        check("stall.ready", {31'h0, in_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall_hold", ADDIU, 32'h3010, 5'h00, 1'b0, 2'd3);
            check("stall.ready_hold", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1; #1;
        check("release.ready", {31'h0, in_ready}, 32'h1);
        step();
        check_out("release_b", ORI, 32'h3014, 5'h00, 1'b0, 2'd3);

        // Flush wins over simultaneous accept and clears delay-slot history
        drive(1'b1, BEQ, 32'h3018); step();
        check_out("beq2", BEQ, 32'h3018, 5'h00, 1'b0, 2'd3);
        flush = 1'b1; drive(1'b1, ADDU, 32'h301C); step();
        check("flush.valid", {31'h0, out_valid}, 32'h0);
        flush = 1'b0; drive(1'b1, ADDU, 32'h3020); step();
        check_out("post_flush", ADDU, 32'h3020, 5'h00, 1'b0, 2'd3);
        drive(1'b0, ADDU, 32'h3024); step();
        check("drain.valid", {31'h0, out_valid}, 32'h0);

        // COP0 words depend on the build
        drive(1'b1, ERET, 32'h3024); step();
        check_out("eret", ERET_OUT, 32'h3024, COP0_CODE, 1'b0, 2'd3);
        drive(1'b1, MFC0, 32'h3028); step();
        check_out("mfc0", MFC0_OUT, 32'h3028, COP0_CODE, 1'b0, 2'd3);

        // REGIMM branch sets delay slot; bltzal is not legal
        drive(1'b1, BLTZ, 32'h302C); step();
        check_out("bltz", BLTZ, 32'h302C, 5'h00, 1'b0, 2'd3);
        drive(1'b1, BLTZAL, 32'h3030); step();
        check_out("bltzal", 32'h0, 32'h3030, 5'h0A, 1'b1, 2'd3);

        // Flush leaves the counter alone
        flush = 1'b1; drive(1'b0, ADDU, 32'h3034); step();
        flush = 1'b0;
        check("flush.cnt", {30'h0, exc_count}, 32'h3);

        // Reset mid-stall after a branch drops the entry and the bd history
        drive(1'b1, BEQ, 32'h3034); step();
        check_out("beq3", BEQ, 32'h3034, 5'h00, 1'b0, 2'd3);
        out_ready = 1'b0; drive(1'b0, ADDU, 32'h3038); #2;
        reset = 1'b0; #1;
        check("arst.valid", {31'h0, out_valid}, 32'h0);
        check("arst.ready", {31'h0, in_ready}, 32'h1);
        check("arst.pc",    out_pc, 32'h0);
        check("arst.cnt",   {30'h0, exc_count}, 32'h0);
        step();
        reset = 1'b1; out_ready = 1'b1;
        drive(1'b1, ADDU, 32'h3038); step();
        check_out("after_rst", ADDU, 32'h3038, 5'h00, 1'b0, 2'd0);

        // Five illegal words: 1,2,3,3,3
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, BAD, 32'h3040 + 32'(i * 4)); step();
            check_out("sat", 32'h0, 32'h3040 + 32'(i * 4), 5'h0A, 1'b0, (i < 3) ? 2'(i + 1) : 2'd3);
        end

        drive(1'b0, 32'h0, 32'h0);
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
